mem_block_mover: RTL and testbench
==================================

// Module: mem_block_mover
// PURPOSE
//  Single-port initiator for data_memory_multi_port: drives one addr/we/data_in/data_out port set.
//  Copies COUNT 16-bit words from a strided source region to a strided destination region.
//  Strides let the matrix cores stage operand rows/columns, transpose tiles and write back results.
//  One move per start pulse; start/busy/done handshake towards the core sequencer.
// PARAMETERS
//  ADDR_W     16    memory address width
//  DATA_W     16    memory word width
//  MEM_DEPTH  1000  number of valid words; an address >= MEM_DEPTH is out of range
// PORTS
//  clk         in   1       system clock, all state on posedge
//  rst         in   1       asynchronous, active-high reset
//  start       in   1       request pulse; sampled only in IDLE
//  src_base    in   ADDR_W  first source address
//  dst_base    in   ADDR_W  first destination address
//  src_stride  in   ADDR_W  source address increment per element (unsigned)
//  dst_stride  in   ADDR_W  destination address increment per element (unsigned)
//  count       in   ADDR_W  number of words to move
//  busy        out  1       high in every non-IDLE state
//  done        out  1       one-cycle pulse at the end of a move, including aborted moves
//  err         out  1       sticky range-error flag; cleared by the next accepted start
//  mem_addr    out  ADDR_W  to memory port addr_n
//  mem_we      out  1       to memory port we_n
//  mem_wdata   out  DATA_W  to memory port data_in_n
//  mem_rdata   in   DATA_W  from memory port data_out_n (combinational read)
// BEHAVIOUR
//  - Reset, asynchronous: state=IDLE; busy=0, done=0, err=0, mem_we=0, mem_addr=0, mem_wdata=0.
//    All internal registers are cleared.
//  - Reset asserted mid-move: mem_we drops in the same cycle. The in-flight write is lost; nothing is resumed.
//  - States: IDLE, RD, WR, FIN.
//    IDLE: when start=1, latch all inputs, clear err, load elem_cnt=count.
//      If count==0, go to FIN; otherwise go to RD.
//    RD: mem_addr=src_ptr, mem_we=0; capture mem_rdata into data_reg at the clock edge.
//      If src_ptr >= MEM_DEPTH: set err, go to FIN, and do not write.
//      Otherwise go to WR.
//    WR: mem_addr=dst_ptr, mem_wdata=data_reg, mem_we=1, but only if dst_ptr < MEM_DEPTH.
//      If dst_ptr >= MEM_DEPTH: mem_we=0, set err, go to FIN.
//      Otherwise: src_ptr+=src_stride, dst_ptr+=dst_stride, elem_cnt-=1.
//      Go to FIN if elem_cnt reaches 0, else go to RD.
//    FIN: done=1 for exactly one cycle, then go to IDLE.
//  - Latency: start sampled at edge 0; count=N>0 with no error gives done high in cycle 2N+1.
//    count=0 gives done high in cycle 1. Peak throughput is one word per 2 cycles.
//  - Pointer arithmetic is ADDR_W-bit unsigned and wraps modulo 2^ADDR_W.
//    A wrapped pointer is checked against MEM_DEPTH like any other pointer; wrap itself is not an error.
//  - start while busy is ignored with no effect. Inputs may change after the accepting edge.
//  - Overlapping regions: strict element order, each read before its write.
//    A forward overlap where dst = src + stride therefore replicates the first word.
//  - mem_addr holds its last value in IDLE and FIN; mem_we=0 outside WR.
//  - done and err are registered outputs; mem_* outputs are decoded from the state registers.
// STRUCTURE
//  - Shared package holds: state encoding constants (IDLE=2'd0, RD=2'd1, WR=2'd2, FIN=2'd3),
//    default ADDR_W/DATA_W/MEM_DEPTH.
//  - One sub-module is natural: mem_block_addr_gen.
//    It is a strided pointer register with load/step/range-check, instantiated twice (src, dst).
//  - FSM and data_reg live in the top level. No other hierarchy.
// TESTING (bench instantiates data_memory_multi_port; the mover drives port 1)
//  1. Preload ram[10..13]=1,2,3,4. Start: src_base=10, dst_base=100, strides=1, count=4.
//     -> ram[100..103]=1,2,3,4; done in cycle 9; err=0.
//  2. Preload a 3x3 matrix at base 0 in row-major order. Start: src_base=1, src_stride=3,
//     dst_base=50, dst_stride=1, count=3.
//     -> column 1 is copied to ram[50..52].
//  3. count=0 -> done in cycle 1; mem_we is never asserted; busy is high for 1 cycle.
//  4. dst_base=998, count=4 -> ram[998] and ram[999] are written, then err=1 and done.
//     No write reaches address 1000.
//  5. Start pulse during busy -> ignored, and the first move completes unchanged.
//     Next start after done clears err.
//  6. Assert rst in the WR cycle of element 2 of 4.
//     -> mem_we=0 immediately, only element 1 is written, and all outputs return to their reset values.

Source files
------------

// File: rtl/mem_block_mover_pkg.sv
// Shared types and defaults for the strided block mover.
// State encoding plus default address/data widths and memory depth.
package mem_block_mover_pkg;

  localparam int ADDR_W_DEF    = 16;
  localparam int DATA_W_DEF    = 16;
  localparam int MEM_DEPTH_DEF = 1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } mv_state_t;

endpackage

// File: rtl/mem_block_mover_addr_gen.sv
// Strided pointer register: load base/stride, step by stride, range check.
// Ports: clk, rst, i_load, i_step, i_base, i_stride -> o_ptr, o_oor.
module mem_block_addr_gen
  import mem_block_mover_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_stride,
  output logic [ADDR_W-1:0] o_ptr,
  output logic              o_oor
);

  // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(MEM_DEPTH);

  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_stride;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= '0;
      r_stride <= '0;
    end else if (i_load) begin
      r_ptr    <= i_base;
      r_stride <= i_stride;
    end else if (i_step) begin
      // Wraps modulo 2**ADDR_W; range check catches the result.
      r_ptr <= r_ptr + r_stride;
    end
  end

  assign o_ptr = r_ptr;
  assign o_oor = {1'b0, r_ptr} >= LIM;

endmodule

// File: rtl/mem_block_mover.sv
// Strided memory-to-memory word mover on a single memory port.
// Ports: start/busy/done/err handshake, strided src/dst setup, mem_* port.
module mem_block_mover
  import mem_block_mover_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] src_stride,
  input  logic [ADDR_W-1:0] dst_stride,
  input  logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  mv_state_t         r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addr_hold;
  logic              r_done;
  logic              r_err;

  logic [ADDR_W-1:0] w_src_ptr;
  logic [ADDR_W-1:0] w_dst_ptr;
  logic              w_src_oor;
  logic              w_dst_oor;
  logic              w_load;
  logic              w_step;

  assign w_load = (r_state == ST_IDLE) && start;
  assign w_step = (r_state == ST_WR) && !w_dst_oor;

  mem_block_addr_gen #(
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_src (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_base   (src_base),
    .i_stride (src_stride),
    .o_ptr    (w_src_ptr),
    .o_oor    (w_src_oor)
  );

  mem_block_addr_gen #(
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_dst (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_base   (dst_base),
    .i_stride (dst_stride),
    .o_ptr    (w_dst_ptr),
    .o_oor    (w_dst_oor)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_data      <= '0;
      r_addr_hold <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_err <= 1'b0;
            r_cnt <= count;
            if (count == '0) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          r_data      <= mem_rdata;
          r_addr_hold <= w_src_ptr;
          if (w_src_oor) begin
            r_err   <= 1'b1;
            r_state <= ST_FIN;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_WR;
          end
        end
        ST_WR: begin
          r_addr_hold <= w_dst_ptr;
          if (w_dst_oor) begin
            r_err   <= 1'b1;
            r_state <= ST_FIN;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == ADDR_W'(1)) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RD;
            end
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Address follows the active pointer; otherwise holds the last one driven.
  always_comb begin
    mem_addr = r_addr_hold;
    unique case (r_state)
      ST_RD:   mem_addr = w_src_ptr;
      ST_WR:   mem_addr = w_dst_ptr;
      default: mem_addr = r_addr_hold;
    endcase
  end

  assign mem_we    = (r_state == ST_WR) && !w_dst_oor;
  assign mem_wdata = r_data;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_block_mover.sv
// Randomized bench for mem_block_mover against a sequential copy model.
// Behavioural 1000-word memory with combinational read on the mover port.
module tb_mem_block_mover;

  localparam int DEPTH = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] src_base = '0;
  logic [15:0] dst_base = '0;
  logic [15:0] src_stride = '0;
  logic [15:0] dst_stride = '0;
  logic [15:0] count = '0;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] ram [0:DEPTH-1];
  logic [15:0] mdl [0:DEPTH-1];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;
  int          n_wr = 0;
  int          n_badwr = 0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_block_mover dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .src_base   (src_base),
    .dst_base   (dst_base),
    .src_stride (src_stride),
    .dst_stride (dst_stride),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = (mem_addr < 16'(DEPTH)) ? ram[mem_addr[9:0]] : 16'h0;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    if (mem_we) begin
      n_wr = n_wr + 1;
      if (mem_addr < 16'(DEPTH)) ram[mem_addr[9:0]] <= mem_wdata;
      else n_badwr = n_badwr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pl(input int a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1;
    pl_addr = 10'(a);
    pl_data = d;
    mdl[a] = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // rst_at: cycle at which reset is asserted (0 = never).
  task automatic run(input string tag, input logic [15:0] sb,
                     input logic [15:0] db, input logic [15:0] ss,
                     input logic [15:0] ds, input logic [15:0] cnt,
                     input bit glitch, input int rst_at);
    int t, ewr, lim, cyc, wr0, nmis, idle_cyc;
    logic eerr;
    logic [15:0] s, d;
    t = 0; ewr = 0; eerr = 1'b0; s = sb; d = db;
    lim = (rst_at > 0) ? rst_at / 2 - 1 : int'(cnt);
    for (int i = 0; i < int'(cnt) && i < lim; i++) begin
      t++;
      if (s >= 16'(DEPTH)) begin eerr = 1'b1; break; end
      t++;
      if (d >= 16'(DEPTH)) begin eerr = 1'b1; break; end
      mdl[d] = mdl[s];
      ewr++;
      s = s + ss;
      d = d + ds;
    end
    @(negedge clk);
    src_base = sb; dst_base = db; src_stride = ss;
    dst_stride = ds; count = cnt; start = 1'b1;
    wr0 = n_wr; cyc = 0; idle_cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 1) chk({tag, "_errclr"}, 32'(err), 0);
      if (rst_at > 0 && cyc == rst_at) begin
        chk({tag, "_we_pre"}, 32'(mem_we), 1);
        rst = 1'b1;
        #1;
        chk({tag, "_rst_we"}, 32'(mem_we), 0);
        chk({tag, "_rst_busy"}, 32'(busy), 0);
        chk({tag, "_rst_done"}, 32'(done), 0);
        chk({tag, "_rst_err"}, 32'(err), 0);
        chk({tag, "_rst_addr"}, 32'(mem_addr), 0);
        chk({tag, "_rst_wdata"}, 32'(mem_wdata), 0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_rst_hold"}, 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        break;
      end
      if (!busy) idle_cyc++;
      if (done) break;
      if (cyc > 300) begin
        chk({tag, "_timeout"}, 32'(cyc), 32'(t + 1));
        break;
      end
      @(negedge clk);
      // After acceptance inputs are free to change; glitch pulses start.
      src_base = 16'($urandom); dst_base = 16'($urandom);
      src_stride = 16'($urandom); dst_stride = 16'($urandom);
      count = 16'($urandom);
      start = glitch ? 1'($urandom) : 1'b0;
    end
    if (rst_at == 0) begin
      chk({tag, "_donecyc"}, 32'(cyc), 32'(t + 1));
      chk({tag, "_err"}, 32'(err), 32'(eerr));
      chk({tag, "_busy"}, 32'(idle_cyc), 0);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "_done1"}, 32'({done, busy}), 0);
    end
    @(negedge clk);
    chk({tag, "_nwr"}, 32'(n_wr - wr0), 32'(ewr));
    nmis = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== mdl[i]) nmis++;
    chk({tag, "_mem"}, 32'(nmis), 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = '0;
      mdl[i] = '0;
    end
    #12;
    chk("rst_state", 32'({busy, done, err, mem_we}), 0);
    chk("rst_addr", 32'({mem_addr, mem_wdata}), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) pl(i, 16'($urandom));

    for (int i = 0; i < 4; i++) pl(10 + i, 16'(i + 1));
    run("t1", 10, 100, 1, 1, 4, 0, 0);
    for (int i = 0; i < 4; i++) chk("t1_val", 32'(ram[100 + i]), 32'(i + 1));

    for (int i = 0; i < 9; i++) pl(i, 16'(16'h100 + i));
    run("t2", 1, 50, 3, 1, 3, 0, 0);
    chk("t2_c0", 32'(ram[50]), 32'h101);
    chk("t2_c1", 32'(ram[51]), 32'h104);
    chk("t2_c2", 32'(ram[52]), 32'h107);

    run("t3", 10, 200, 1, 1, 0, 0, 0);
    run("t4", 20, 998, 1, 1, 4, 0, 0);
    chk("t4_err", 32'(err), 1);
    run("t5", 30, 300, 2, 1, 5, 1, 0);
    run("t6", 40, 400, 1, 1, 4, 0, 4);
    run("ovl", 600, 601, 1, 1, 6, 0, 0);
    run("wrap", 2, 700, 16'hFFFF, 1, 4, 0, 0);
    run("srcoor", 997, 710, 1, 1, 5, 0, 0);

    for (int k = 0; k < 40; k++) begin
      logic [15:0] sb, db, ss, ds, cn;
      sb = 16'($urandom_range(0, 1010));
      db = 16'($urandom_range(0, 1010));
      ss = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 5));
      ds = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom_range(0, 5));
      cn = 16'($urandom_range(0, 9));
      run("rnd", sb, db, ss, ds, cn, 1'($urandom), 0);
    end
    chk("no_oor_wr", 32'(n_badwr), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
